// File: rtl/spart_pkg.sv
// Shared SPART definitions: bus register map, status bit positions, baud divisors
// and the echo driver state encoding.
package spart_pkg;

  typedef enum logic [2:0] {
    StInitLo,
    StInitHi,
    StPollRx,
    StReadRx,
    StPollTx,
    StWriteTx
  } state_e;

  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_STAT   = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  localparam int unsigned STAT_TBR_BIT = 0;
  localparam int unsigned STAT_RDA_BIT = 1;

  // floor(100 MHz / (16 * baud)) - 1
  localparam logic [15:0] DIV_4800  = 16'h0515;
  localparam logic [15:0] DIV_9600  = 16'h028A;
  localparam logic [15:0] DIV_19200 = 16'h0144;
  localparam logic [15:0] DIV_38400 = 16'h00A1;

  function automatic logic [15:0] div_for_cfg(input logic [1:0] cfg);
    logic [15:0] div;
    unique case (cfg)
      2'b00:   div = DIV_4800;
      2'b01:   div = DIV_9600;
      2'b10:   div = DIV_19200;
      default: div = DIV_38400;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/spart_sync2.sv
// Two-flop synchronizer for slow asynchronous level inputs such as DIP switches.
module spart_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // No reset: the switches keep being sampled while the system is held in reset.
  always_ff @(posedge i_clk) begin
    r_meta <= i_d;
    r_sync <= r_meta;
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spart_echo_driver.sv
// SPART bus master: programs the baud divisor from br_cfg, then polls the SPART
// and writes every received byte (optionally XORed) back to the transmitter.
module spart_echo_driver
  import spart_pkg::*;
#(
  parameter logic [7:0]  ECHO_XOR = 8'h00,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       br_cfg,
  output logic             iocs,
  output logic             iorw,
  output logic [1:0]       ioaddr,
  output logic [7:0]       bus_wdata,
  input  logic [7:0]       bus_rdata,
  output logic [7:0]       rx_byte,
  output logic             rx_valid,
  output logic [CNT_W-1:0] echo_count
);

  logic [1:0]       w_cfg_sync;
  logic             w_cfg_change;
  logic [15:0]      w_div_new;
  logic [15:0]      w_div_cur;
  state_e           w_state_d;
  logic             w_iocs;
  logic             w_iorw;
  logic [1:0]       w_ioaddr;
  logic [7:0]       w_wdata;

  state_e           r_state;
  logic             r_go;
  logic [1:0]       r_cfg;
  logic [7:0]       r_hold;
  logic [7:0]       r_rx_byte;
  logic             r_rx_valid;
  logic [CNT_W-1:0] r_echo_count;
  logic             r_iocs;
  logic             r_iorw;
  logic [1:0]       r_ioaddr;
  logic [7:0]       r_wdata;

  spart_sync2 #(
    .WIDTH(2)
  ) u_cfg_sync (
    .i_clk(clk),
    .i_d  (br_cfg),
    .o_q  (w_cfg_sync)
  );

  assign w_cfg_change = (w_cfg_sync != r_cfg);
  assign w_div_new    = div_for_cfg(w_cfg_sync);
  assign w_div_cur    = div_for_cfg(r_cfg);

  // r_state names the access currently on the bus; r_go marks that one has been issued.
  always_comb begin
    w_state_d = r_state;
    if (r_go) begin
      unique case (r_state)
        StInitLo:  w_state_d = StInitHi;
        StInitHi:  w_state_d = StPollRx;
        StPollRx: begin
          if (w_cfg_change) begin
            w_state_d = StInitLo;
          end else if (bus_rdata[STAT_RDA_BIT]) begin
            w_state_d = StReadRx;
          end
        end
        StReadRx:  w_state_d = StPollTx;
        StPollTx: begin
          if (bus_rdata[STAT_TBR_BIT]) begin
            w_state_d = StWriteTx;
          end
        end
        StWriteTx: w_state_d = StPollRx;
        default:   w_state_d = StInitLo;
      endcase
    end
  end

  always_comb begin
    w_iocs   = 1'b1;
    w_iorw   = 1'b1;
    w_ioaddr = ADDR_STAT;
    w_wdata  = 8'h00;
    unique case (w_state_d)
      StInitLo: begin
        w_iorw   = 1'b0;
        w_ioaddr = ADDR_DIV_LO;
        w_wdata  = w_div_new[7:0];
      end
      StInitHi: begin
        w_iorw   = 1'b0;
        w_ioaddr = ADDR_DIV_HI;
        w_wdata  = w_div_cur[15:8];
      end
      StReadRx: w_ioaddr = ADDR_BUF;
      StWriteTx: begin
        w_iorw   = 1'b0;
        w_ioaddr = ADDR_BUF;
        w_wdata  = r_hold;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StInitLo;
      r_go         <= 1'b0;
      r_cfg        <= 2'b00;
      r_hold       <= 8'h00;
      r_rx_byte    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_echo_count <= '0;
      r_iocs       <= 1'b0;
      r_iorw       <= 1'b1;
      r_ioaddr     <= ADDR_BUF;
      r_wdata      <= 8'h00;
    end else begin
      r_go       <= 1'b1;
      r_state    <= w_state_d;
      r_iocs     <= w_iocs;
      r_iorw     <= w_iorw;
      r_ioaddr   <= w_ioaddr;
      r_wdata    <= w_wdata;
      r_rx_valid <= 1'b0;
      if (w_state_d == StInitLo) begin
        r_cfg <= w_cfg_sync;
      end
      if (r_go && r_state == StReadRx) begin
        r_rx_byte  <= bus_rdata;
        r_hold     <= bus_rdata ^ ECHO_XOR;
        r_rx_valid <= 1'b1;
      end
      if (r_go && r_state == StWriteTx) begin
        r_echo_count <= r_echo_count + CNT_W'(1);
      end
    end
  end

  assign iocs       = r_iocs;
  assign iorw       = r_iorw;
  assign ioaddr     = r_ioaddr;
  assign bus_wdata  = r_wdata;
  assign rx_byte    = r_rx_byte;
  assign rx_valid   = r_rx_valid;
  assign echo_count = r_echo_count;

endmodule

// File: tb/tb_spart_echo_driver.sv
// Bench: two drivers (ECHO_XOR 00 and 20) on behavioural SPART bus models with an
// optional delayed tx->rx loopback; bus writes are scoreboarded against expectations.
module tb_spart_echo_driver;

  localparam int N = 2;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic [1:0] br_cfg = 2'b00;

  logic        iocs       [N];
  logic        iorw       [N];
  logic [1:0]  ioaddr     [N];
  logic [7:0]  bus_wdata  [N];
  logic [7:0]  bus_rdata  [N];
  logic [7:0]  rx_byte    [N];
  logic        rx_valid   [N];
  logic [15:0] echo_count [N];

  bit        m_rda       [N];
  bit [7:0]  m_rxbuf     [N];
  bit [15:0] m_div       [N];
  bit [5:0]  lb_cnt      [N];
  bit [7:0]  lb_byte     [N];
  bit        m_tbr       [N];
  bit        rx_req      [N];
  bit [7:0]  rx_req_byte [N];
  bit        loop_en     [N];

  logic [9:0] exp_q0 [$];
  logic [9:0] exp_q1 [$];
  logic [9:0] obs_q0 [$];
  logic [9:0] obs_q1 [$];
  logic [7:0] rxv_q0 [$];
  logic [7:0] rxv_q1 [$];

  int errors   = 0;
  int checks   = 0;
  int n_wr0    = 0;
  int n_bufrd0 = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    spart_echo_driver #(
      .ECHO_XOR((g == 1) ? 8'h20 : 8'h00),
      .CNT_W   (16)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .br_cfg    (br_cfg),
      .iocs      (iocs[g]),
      .iorw      (iorw[g]),
      .ioaddr    (ioaddr[g]),
      .bus_wdata (bus_wdata[g]),
      .bus_rdata (bus_rdata[g]),
      .rx_byte   (rx_byte[g]),
      .rx_valid  (rx_valid[g]),
      .echo_count(echo_count[g])
    );
  end

  // SPART bus model: status {RDA,TBR}, rx buffer, divisor regs, delayed loopback
  always_comb begin
    for (int k = 0; k < N; k++) begin
      bus_rdata[k] = 8'h00;
      if (ioaddr[k] == 2'b01) bus_rdata[k] = {6'b0, m_rda[k], m_tbr[k]};
      else if (ioaddr[k] == 2'b00) bus_rdata[k] = m_rxbuf[k];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (lb_cnt[k] != 0) begin
        lb_cnt[k] <= lb_cnt[k] - 6'd1;
        if (lb_cnt[k] == 6'd1) begin
          m_rda[k]   <= 1'b1;
          m_rxbuf[k] <= lb_byte[k];
        end
      end
      if (rx_req[k]) begin
        m_rda[k]   <= 1'b1;
        m_rxbuf[k] <= rx_req_byte[k];
      end
      if (iocs[k] && iorw[k] && ioaddr[k] == 2'b00) m_rda[k] <= 1'b0;
      if (iocs[k] && !iorw[k]) begin
        case (ioaddr[k])
          2'b10: m_div[k][7:0] <= bus_wdata[k];
          2'b11: m_div[k][15:8] <= bus_wdata[k];
          2'b00: begin
            if (loop_en[k]) begin
              lb_cnt[k]  <= 6'd20;
              lb_byte[k] <= bus_wdata[k];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (iocs[0] && !iorw[0]) begin
      obs_q0.push_back({ioaddr[0], bus_wdata[0]});
      n_wr0 <= n_wr0 + 1;
    end
    if (iocs[0] && iorw[0] && ioaddr[0] == 2'b00) n_bufrd0 <= n_bufrd0 + 1;
    if (iocs[1] && !iorw[1]) obs_q1.push_back({ioaddr[1], bus_wdata[1]});
    if (rx_valid[0]) rxv_q0.push_back(rx_byte[0]);
    if (rx_valid[1]) rxv_q1.push_back(rx_byte[1]);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_rx(input int k, input logic [7:0] b);
    rx_req_byte[k] = b;
    rx_req[k]      = 1'b1;
    tick();
    rx_req[k]      = 1'b0;
  endtask

  task automatic wait_obs(input int k, input int n, input int budget, output bit ok,
                          output int waited);
    ok     = 1'b0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      if (((k == 0) ? obs_q0.size() : obs_q1.size()) >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
      waited++;
    end
    if (((k == 0) ? obs_q0.size() : obs_q1.size()) >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    logic [36:0] got;
    logic [9:0]  e, o;
    bit          ok;
    int          w;
    rst = 1'b1; br_cfg = 2'b00; m_tbr[0] = 1'b1; m_tbr[1] = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < N; k++) begin
      got = {iocs[k], iorw[k], ioaddr[k], bus_wdata[k], rx_byte[k], rx_valid[k], echo_count[k]};
      checks++;
      if (got !== {1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 16'h0000}) begin
        errors++;
        $display("FAIL reset_values[%0d]: got %h want %h", k, got,
                 {1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 16'h0000});
      end
    end
    exp_q0.push_back({2'b10, 8'h15}); exp_q0.push_back({2'b11, 8'h05});
    exp_q1.push_back({2'b10, 8'h15}); exp_q1.push_back({2'b11, 8'h05});
    rst = 1'b0;
    tick();
    checks++;
    if ({iocs[0], iorw[0], ioaddr[0], bus_wdata[0]} !== {1'b1, 1'b0, 2'b10, 8'h15}) begin
      errors++;
      $display("FAIL first_cycle_write: got cs=%b rw=%b addr=%0d data=%h want 1 0 2 15",
               iocs[0], iorw[0], ioaddr[0], bus_wdata[0]);
    end
    wait_obs(1, 2, 10, ok, w);
    wait_obs(0, 2, 10, ok, w);
    while (exp_q0.size() != 0) begin
      e = exp_q0.pop_front();
      o = (obs_q0.size() != 0) ? obs_q0.pop_front() : 10'h3ff;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL init_write0: got %0d/%h want %0d/%h", o[9:8], o[7:0], e[9:8], e[7:0]);
      end
    end
    while (exp_q1.size() != 0) begin
      e = exp_q1.pop_front();
      o = (obs_q1.size() != 0) ? obs_q1.pop_front() : 10'h3ff;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL init_write1: got %0d/%h want %0d/%h", o[9:8], o[7:0], e[9:8], e[7:0]);
      end
    end
  endtask

  task automatic test_echo();
    logic [9:0] e, o;
    logic [7:0] r;
    bit         ok;
    int         w;
    exp_q0.push_back({2'b00, 8'h41});
    send_rx(0, 8'h41);
    wait_obs(0, 1, 20, ok, w);
    checks++;
    if (!ok || w != 3) begin
      errors++;
      $display("FAIL echo_latency: got arrived=%0d after %0d cycles want 1 after 3", ok, w);
    end
    e = exp_q0.pop_front();
    o = (obs_q0.size() != 0) ? obs_q0.pop_front() : 10'h3ff;
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL echo_write: got %0d/%h want %0d/%h", o[9:8], o[7:0], e[9:8], e[7:0]);
    end
    r = (rxv_q0.size() != 0) ? rxv_q0.pop_front() : 8'hxx;
    checks++;
    if (r !== 8'h41) begin
      errors++;
      $display("FAIL echo_rx_valid: got rx_byte %h at pulse want 41", r);
    end
    tick();
    checks++;
    if (echo_count[0] !== 16'd1) begin
      errors++;
      $display("FAIL echo_count1: got %0d want 1", echo_count[0]);
    end
  endtask

  task automatic test_tbr_wait();
    logic [9:0] e, o;
    logic [7:0] r;
    bit         ok;
    int         w, w0, b0;
    m_tbr[0] = 1'b0;
    exp_q0.push_back({2'b00, 8'h41});
    w0 = n_wr0; b0 = n_bufrd0;
    send_rx(0, 8'h41);
    repeat (50) tick();
    checks++;
    if (n_wr0 - w0 != 0 || n_bufrd0 - b0 != 1) begin
      errors++;
      $display("FAIL tbr_wait_accesses: got writes=%0d buf_reads=%0d want 0 and 1",
               n_wr0 - w0, n_bufrd0 - b0);
    end
    m_tbr[0] = 1'b1;
    wait_obs(0, 1, 10, ok, w);
    checks++;
    if (!ok || w != 1) begin
      errors++;
      $display("FAIL tbr_release_latency: got arrived=%0d after %0d want 1 after 1", ok, w);
    end
    e = exp_q0.pop_front();
    o = (obs_q0.size() != 0) ? obs_q0.pop_front() : 10'h3ff;
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL tbr_write: got %0d/%h want %0d/%h", o[9:8], o[7:0], e[9:8], e[7:0]);
    end
    r = (rxv_q0.size() != 0) ? rxv_q0.pop_front() : 8'hxx;
    tick();
    checks++;
    if (r !== 8'h41 || echo_count[0] !== 16'd2) begin
      errors++;
      $display("FAIL tbr_rx_count: got rx=%h count=%0d want 41 and 2", r, echo_count[0]);
    end
  endtask

  task automatic test_xor();
    logic [9:0] e, o;
    logic [7:0] r;
    bit         ok;
    int         w;
    exp_q1.push_back({2'b00, 8'h41});
    send_rx(1, 8'h61);
    wait_obs(1, 1, 20, ok, w);
    e = exp_q1.pop_front();
    o = (obs_q1.size() != 0) ? obs_q1.pop_front() : 10'h3ff;
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL xor_write: got %0d/%h want %0d/%h", o[9:8], o[7:0], e[9:8], e[7:0]);
    end
    r = (rxv_q1.size() != 0) ? rxv_q1.pop_front() : 8'hxx;
    tick();
    checks++;
    if (r !== 8'h61 || rx_byte[1] !== 8'h61 || echo_count[1] !== 16'd1) begin
      errors++;
      $display("FAIL xor_rx: got pulse=%h rx_byte=%h count=%0d want 61 61 1",
               r, rx_byte[1], echo_count[1]);
    end
  endtask

  task automatic test_cfg_change();
    logic [9:0] e, o;
    logic [7:0] r;
    bit         ok;
    int         w;
    m_tbr[0] = 1'b0;
    send_rx(0, 8'h55);
    repeat (4) tick();
    exp_q0.push_back({2'b00, 8'h55});
    exp_q0.push_back({2'b10, 8'hA1});
    exp_q0.push_back({2'b11, 8'h00});
    exp_q1.push_back({2'b10, 8'hA1});
    exp_q1.push_back({2'b11, 8'h00});
    br_cfg = 2'b11;
    repeat (8) tick();
    m_tbr[0] = 1'b1;
    wait_obs(0, 3, 20, ok, w);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cfg_timeout: got %0d writes want 3", obs_q0.size());
    end
    while (exp_q0.size() != 0) begin
      e = exp_q0.pop_front();
      o = (obs_q0.size() != 0) ? obs_q0.pop_front() : 10'h3ff;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL cfg_write0: got %0d/%h want %0d/%h", o[9:8], o[7:0], e[9:8], e[7:0]);
      end
    end
    while (exp_q1.size() != 0) begin
      e = exp_q1.pop_front();
      o = (obs_q1.size() != 0) ? obs_q1.pop_front() : 10'h3ff;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL cfg_write1: got %0d/%h want %0d/%h", o[9:8], o[7:0], e[9:8], e[7:0]);
      end
    end
    r = (rxv_q0.size() != 0) ? rxv_q0.pop_front() : 8'hxx;
    tick();
    checks++;
    if (r !== 8'h55 || echo_count[0] !== 16'd3 || m_div[0] !== 16'h00A1) begin
      errors++;
      $display("FAIL cfg_state: got rx=%h count=%0d div=%h want 55 3 00a1",
               r, echo_count[0], m_div[0]);
    end
  endtask

  task automatic test_reset_loopback();
    logic [9:0]  e, o;
    logic [7:0]  r1, r2;
    logic [36:0] got;
    bit          ok;
    int          w;
    exp_q0.push_back({2'b10, 8'h15}); exp_q0.push_back({2'b11, 8'h05});
    exp_q1.push_back({2'b10, 8'h15}); exp_q1.push_back({2'b11, 8'h05});
    br_cfg = 2'b00;
    repeat (8) tick();
    m_tbr[0] = 1'b0;
    send_rx(0, 8'h77);
    repeat (4) tick();
    r1 = (rxv_q0.size() != 0) ? rxv_q0.pop_front() : 8'hxx;
    checks++;
    if (r1 !== 8'h77) begin
      errors++;
      $display("FAIL pre_reset_rx: got %h want 77", r1);
    end
    rst = 1'b1;
    #1;
    got = {iocs[0], iorw[0], ioaddr[0], bus_wdata[0], rx_byte[0], rx_valid[0], echo_count[0]};
    checks++;
    if (got !== {1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", got,
               {1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 16'h0000});
    end
    repeat (2) tick();
    exp_q0.push_back({2'b10, 8'h15}); exp_q0.push_back({2'b11, 8'h05});
    exp_q0.push_back({2'b00, 8'h40}); exp_q0.push_back({2'b00, 8'h40});
    exp_q1.push_back({2'b10, 8'h15}); exp_q1.push_back({2'b11, 8'h05});
    m_tbr[0] = 1'b1; loop_en[0] = 1'b1;
    rst = 1'b0;
    wait_obs(0, 4, 10, ok, w);
    send_rx(0, 8'h40);
    wait_obs(0, 6, 150, ok, w);
    loop_en[0] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL loopback_timeout: got %0d writes want 6", obs_q0.size());
    end
    while (exp_q0.size() != 0) begin
      e = exp_q0.pop_front();
      o = (obs_q0.size() != 0) ? obs_q0.pop_front() : 10'h3ff;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL loop_write0: got %0d/%h want %0d/%h", o[9:8], o[7:0], e[9:8], e[7:0]);
      end
    end
    while (exp_q1.size() != 0) begin
      e = exp_q1.pop_front();
      o = (obs_q1.size() != 0) ? obs_q1.pop_front() : 10'h3ff;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL loop_write1: got %0d/%h want %0d/%h", o[9:8], o[7:0], e[9:8], e[7:0]);
      end
    end
    r1 = (rxv_q0.size() != 0) ? rxv_q0.pop_front() : 8'hxx;
    r2 = (rxv_q0.size() != 0) ? rxv_q0.pop_front() : 8'hxx;
    tick();
    checks++;
    if (r1 !== 8'h40 || r2 !== 8'h40 || echo_count[0] !== 16'd2 || m_div[0] !== 16'h0515) begin
      errors++;
      $display("FAIL loopback_state: got rx=%h,%h count=%0d div=%h want 40,40 2 0515",
               r1, r2, echo_count[0], m_div[0]);
    end
    repeat (40) tick();
    checks++;
    if (obs_q0.size() != 0 || obs_q1.size() != 0 || rxv_q0.size() != 0) begin
      errors++;
      $display("FAIL stray_activity: got writes=%0d,%0d rx_pulses=%0d want 0,0,0",
               obs_q0.size(), obs_q1.size(), rxv_q0.size());
    end
  endtask

  initial begin
    test_reset();
    repeat (3) tick();
    test_echo();
    repeat (3) tick();
    test_tbr_wait();
    repeat (3) tick();
    test_xor();
    repeat (3) tick();
    test_cfg_change();
    repeat (3) tick();
    test_reset_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
